// File: rtl/nf2_sim_activity_watchdog.sv
// nf2_sim_activity_watchdog
// Purpose:      waits for host bring-up, then emits a periodic heartbeat, counts frame starts per
//               port, flags idle ports and raises a global timeout when no port sees a frame start.
// Latency:      all outputs registered; frame_count follows port_sel by one cycle.
// Backpressure: none; a passive monitor that never stalls the traffic it observes.
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high; returns every register to its idle value
//   system_up    level, high once host configuration is complete
//   port_dv      per-port data-valid level; a rising edge is one frame start
//   clear_stats  one-cycle pulse: zeroes frame counters and the timeout counter
//   port_sel     port index for frame_count readout (values >= NUM_PORTS read 0)
//   state        0=WAIT_UP, 1=RUN, 2=TIMEOUT
//   up_pulse     one-cycle pulse on entry to RUN from WAIT_UP
//   heartbeat    one-cycle pulse every HEARTBEAT_CYCLES while in RUN
//   port_idle    bit i high while port i has gone IDLE_CYCLES without a frame start
//   timeout      high while in TIMEOUT
//   frame_count  registered frame count of port port_sel
module nf2_sim_activity_watchdog #(
  parameter int NUM_PORTS        = 4,
  parameter int HEARTBEAT_CYCLES = 10000,
  parameter int IDLE_CYCLES      = 5000,
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 system_up,
  input  logic [NUM_PORTS-1:0] port_dv,
  input  logic                 clear_stats,
  input  logic [3:0]           port_sel,
  output logic [1:0]           state,
  output logic                 up_pulse,
  output logic                 heartbeat,
  output logic [NUM_PORTS-1:0] port_idle,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] frame_count
);

  // The cycle counters are sized from their own limits rather than CNT_WIDTH, so a narrow
  // frame counter (e.g. for saturation testing) never truncates the heartbeat or timeout period.
  localparam int HB_W   = $clog2(HEARTBEAT_CYCLES);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [HB_W-1:0]      HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(IDLE_CYCLES);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] FC_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT_UP = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t                 st_q, st_d;
  logic [NUM_PORTS-1:0]   dv_q;
  logic [NUM_PORTS-1:0]   frame_start;
  logic                   any_start;

  logic [HB_W-1:0]        hb_cnt_q, hb_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [IDLE_W-1:0]      idle_cnt_q  [NUM_PORTS];
  logic [IDLE_W-1:0]      idle_cnt_d  [NUM_PORTS];
  logic [CNT_WIDTH-1:0]   frame_cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0]   frame_cnt_d [NUM_PORTS];

  logic                   up_pulse_d;
  logic                   heartbeat_d;
  logic [CNT_WIDTH-1:0]   frame_count_d;
  logic                   restart;

  // Frame starts only count in RUN; the dv history itself tracks the inputs in every state
  // so a level already high on entry to RUN is not mistaken for a new frame.
  always_comb begin
    frame_start = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      frame_start[i] = (st_q == ST_RUN) && port_dv[i] && !dv_q[i];
    end
    any_start = |frame_start;
  end

  // Next-state and next-output logic.
  always_comb begin
    st_d        = st_q;
    up_pulse_d  = 1'b0;
    heartbeat_d = 1'b0;
    hb_cnt_d    = hb_cnt_q;
    to_cnt_d    = to_cnt_q;
    restart     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idle_cnt_d[i] = idle_cnt_q[i];
    end

    case (st_q)
      ST_WAIT_UP: begin
        if (system_up) begin
          st_d       = ST_RUN;
          up_pulse_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (!system_up) begin
          // Host went away: park, drop idle flags, keep the frame statistics.
          st_d    = ST_WAIT_UP;
          restart = 1'b1;
        end else begin
          if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d    = '0;
            heartbeat_d = 1'b1;
          end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
          end

          for (int i = 0; i < NUM_PORTS; i++) begin
            if (frame_start[i]) begin
              idle_cnt_d[i] = '0;
            end else if (idle_cnt_q[i] != IDLE_MAX) begin
              idle_cnt_d[i] = idle_cnt_q[i] + IDLE_W'(1);
            end
          end

          // A clear also restarts the no-traffic window, so it can never trip on the same edge.
          if (any_start || clear_stats) begin
            to_cnt_d = '0;
          end else if (to_cnt_q == TO_LAST) begin
            st_d = ST_TIMEOUT;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      ST_TIMEOUT: begin
        // Counters hold here; the heartbeat pauses until traffic monitoring resumes.
        if (!system_up) begin
          st_d    = ST_WAIT_UP;
          restart = 1'b1;
        end else if (clear_stats) begin
          st_d    = ST_RUN;
          restart = 1'b1;
        end
      end

      default: begin
        st_d    = ST_WAIT_UP;
        restart = 1'b1;
      end
    endcase

    // Every exit from RUN/TIMEOUT, and a recovery from TIMEOUT, starts the timing windows fresh.
    if (restart) begin
      hb_cnt_d = '0;
      to_cnt_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        idle_cnt_d[i] = '0;
      end
    end
  end

  // Frame counters: clear has priority over a coincident frame start; saturate at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (clear_stats) begin
        frame_cnt_d[i] = '0;
      end else if (frame_start[i] && (frame_cnt_q[i] != FC_MAX)) begin
        frame_cnt_d[i] = frame_cnt_q[i] + CNT_WIDTH'(1);
      end else begin
        frame_cnt_d[i] = frame_cnt_q[i];
      end
    end
  end

  // Readout mux; an index beyond the last port matches nothing and reads zero.
  always_comb begin
    frame_count_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_sel == 4'(i)) begin
        frame_count_d = frame_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_WAIT_UP;
      dv_q        <= '0;
      hb_cnt_q    <= '0;
      to_cnt_q    <= '0;
      up_pulse    <= 1'b0;
      heartbeat   <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        idle_cnt_q[i]  <= '0;
        frame_cnt_q[i] <= '0;
      end
    end else begin
      st_q        <= st_d;
      dv_q        <= port_dv;
      hb_cnt_q    <= hb_cnt_d;
      to_cnt_q    <= to_cnt_d;
      up_pulse    <= up_pulse_d;
      heartbeat   <= heartbeat_d;
      frame_count <= frame_count_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        idle_cnt_q[i]  <= idle_cnt_d[i];
        frame_cnt_q[i] <= frame_cnt_d[i];
      end
    end
  end

  always_comb begin
    port_idle = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_idle[i] = (idle_cnt_q[i] == IDLE_MAX);
    end
  end

  assign state   = st_q;
  assign timeout = (st_q == ST_TIMEOUT);

endmodule

// File: tb/tb_nf2_sim_activity_watchdog.sv
// Bench for nf2_sim_activity_watchdog: directed bring-up/idle/timeout/saturation sequences,
// a table of per-cycle vectors, and randomized traffic checked against a timestamp model.
module tb_nf2_sim_activity_watchdog;
  localparam int NP     = 4;
  localparam int HB     = 10;
  localparam int IDL    = 50;
  localparam int TO     = 100;
  localparam int CW     = 3;
  localparam int FC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sup;
  logic [NP-1:0] dv;
  logic          clr;
  logic [3:0]    sel;
  logic [1:0]    state;
  logic          up_pulse;
  logic          heartbeat;
  logic [NP-1:0] port_idle;
  logic          timeout;
  logic [CW-1:0] frame_count;

  nf2_sim_activity_watchdog #(
    .NUM_PORTS(NP), .HEARTBEAT_CYCLES(HB), .IDLE_CYCLES(IDL),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(rst), .system_up(sup), .port_dv(dv), .clear_stats(clr),
    .port_sel(sel), .state(state), .up_pulse(up_pulse), .heartbeat(heartbeat),
    .port_idle(port_idle), .timeout(timeout), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: timestamps of the events that restart each window, plus plain counts.
  int      m_state = 0;
  bit      m_up = 0, m_hb = 0;
  int      m_fco = 0;
  int      base = 0, to_ref = 0, t_to = 0;
  int      ref_fs [NP];
  int      fc     [NP];
  bit [NP-1:0] dvp = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic restart_windows();
    base   = cyc;
    to_ref = cyc;
    for (int i = 0; i < NP; i++) ref_fs[i] = cyc;
  endtask

  task automatic model_step();
    int          old;
    bit [NP-1:0] fs;
    cyc++;
    if (rst) begin
      m_state = 0; m_up = 0; m_hb = 0; m_fco = 0; dvp = '0;
      for (int i = 0; i < NP; i++) fc[i] = 0;
      return;
    end
    old = m_state;
    for (int i = 0; i < NP; i++) fs[i] = (old == 1) && dv[i] && !dvp[i];
    m_fco = (int'(sel) < NP) ? fc[sel] : 0;
    m_up = 0;
    m_hb = 0;
    case (old)
      0: if (sup) begin m_state = 1; m_up = 1; restart_windows(); end
      1: begin
        if (!sup) m_state = 0;
        else begin
          m_hb = ((cyc - base) % HB) == 0;
          for (int i = 0; i < NP; i++) if (fs[i]) ref_fs[i] = cyc;
          if ((|fs) || clr) to_ref = cyc;
          else if (cyc - to_ref == TO) begin m_state = 2; t_to = cyc; end
        end
      end
      default: begin
        if (!sup) m_state = 0;
        else if (clr) begin m_state = 1; restart_windows(); end
      end
    endcase
    for (int i = 0; i < NP; i++) begin
      if (clr) fc[i] = 0;
      else if (fs[i] && fc[i] < FC_MAX) fc[i]++;
    end
    dvp = dv;
  endtask

  function automatic logic [NP-1:0] exp_idle();
    logic [NP-1:0] r = '0;
    for (int i = 0; i < NP; i++) begin
      if (m_state == 1) r[i] = (cyc - ref_fs[i]) >= IDL;
      else if (m_state == 2) r[i] = (t_to - ref_fs[i]) >= IDL;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("model_state", int'(state), m_state);
    chk("model_up_pulse", int'(up_pulse), int'(m_up));
    chk("model_heartbeat", int'(heartbeat), int'(m_hb));
    chk("model_port_idle", int'(port_idle), int'(exp_idle()));
    chk("model_timeout", int'(timeout), int'(m_state == 2));
    chk("model_frame_count", int'(frame_count), m_fco);
  endtask

  typedef struct {
    bit          rst;
    bit          sup;
    bit [NP-1:0] dv;
    bit          clr;
    bit [3:0]    sel;
    bit [1:0]    e_state;
    bit          e_up;
    bit          e_hb;
    bit [NP-1:0] e_idle;
    bit [CW-1:0] e_fc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int k;
    int hb_seen;
    rst = 1'b1; sup = 1'b0; dv = '0; clr = 1'b0; sel = 4'd0;

    // ---------------- bring-up and heartbeat ----------------
    for (int j = 0; j < 5; j++) tick();
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'({up_pulse, heartbeat, timeout, port_idle, frame_count}), 0);
    rst = 1'b0;
    for (int j = 0; j < 14; j++) tick();
    chk("wait_up_state", int'(state), 0);
    sup = 1'b1;
    tick(); k = 0;
    chk("up_pulse_entry", int'(up_pulse), 1);
    chk("run_entry_state", int'(state), 1);
    for (int j = 1; j <= 40; j++) begin
      tick(); k = j;
      chk("heartbeat_period", int'(heartbeat), int'((j % HB) == 0));
      chk("up_pulse_once", int'(up_pulse), 0);
    end

    // ---------------- idle detection ----------------
    sel = 4'd1;
    while (k < 49) begin tick(); k++; end
    chk("idle_before_limit", int'(port_idle), 0);
    tick(); k++;
    chk("idle_at_limit", int'(port_idle), 4'b1111);
    while (k < 59) begin tick(); k++; end
    dv = 4'b0010;
    tick(); k++;
    chk("idle_cleared_by_frame", int'(port_idle), 4'b1101);

    // ---------------- global timeout ----------------
    while (k < 159) begin tick(); k++; end
    chk("no_timeout_yet", int'(state), 1);
    tick(); k++;
    chk("timeout_state", int'(state), 2);
    chk("timeout_flag", int'(timeout), 1);
    hb_seen = 0;
    while (k < 180) begin
      if (k == 164) dv = 4'b0000;
      if (k == 166) dv = 4'b0010;
      if (k == 168) dv = 4'b0000;
      tick(); k++;
      if (heartbeat) hb_seen++;
    end
    chk("heartbeat_stopped", hb_seen, 0);
    chk("frame_count_frozen", int'(frame_count), 1);
    clr = 1'b1;
    tick(); k++;
    clr = 1'b0;
    chk("clear_back_to_run", int'(state), 1);
    chk("clear_no_up_pulse", int'(up_pulse), 0);
    tick(); k++;
    chk("clear_zero_count", int'(frame_count), 0);

    // ---------------- saturation and clear/frame collision ----------------
    for (int n = 0; n < 9; n++) begin
      dv = 4'b1000; tick();
      dv = 4'b0000; tick();
    end
    sel = 4'd3;
    tick();
    chk("frame_count_saturated", int'(frame_count), FC_MAX);
    dv = 4'b1000; clr = 1'b1;
    tick();
    dv = 4'b0000; clr = 1'b0;
    tick();
    chk("clear_beats_frame", int'(frame_count), 0);

    // ---------------- reset mid-RUN ----------------
    dv = 4'b1111;
    rst = 1'b1;
    tick();
    chk("midrun_reset_state", int'(state), 0);
    chk("midrun_reset_outputs", int'({up_pulse, heartbeat, timeout, port_idle, frame_count}), 0);
    rst = 1'b0; dv = '0;

    // ---------------- table-driven vectors ----------------
    //           rst  sup  dv       clr  sel    st    up  hb  idle     fc
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 4'h4, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'd2, 2'd1, 1'b0, 1'b0, 4'h0, 3'd1};
    tbl[5]  = '{1'b0, 1'b1, 4'h4, 1'b0, 4'd2, 2'd1, 1'b0, 1'b0, 4'h0, 3'd1};
    tbl[6]  = '{1'b0, 1'b1, 4'h4, 1'b0, 4'd2, 2'd1, 1'b0, 1'b0, 4'h0, 3'd2};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'd7, 2'd1, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[8]  = '{1'b0, 1'b1, 4'h4, 1'b1, 4'd2, 2'd1, 1'b0, 1'b0, 4'h0, 3'd2};
    tbl[9]  = '{1'b0, 1'b1, 4'h4, 1'b0, 4'd2, 2'd1, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[10] = '{1'b0, 1'b1, 4'h1, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 4'h0, 3'd0};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 4'h0, 3'd1};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'h0, 3'd1};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'h0, 3'd1};
    tbl[14] = '{1'b1, 1'b1, 4'h0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'h0, 3'd0};
    for (int r = 0; r < 15; r++) begin
      rst = tbl[r].rst; sup = tbl[r].sup; dv = tbl[r].dv; clr = tbl[r].clr; sel = tbl[r].sel;
      tick();
      chk($sformatf("tbl%0d_state", r), int'(state), int'(tbl[r].e_state));
      chk($sformatf("tbl%0d_up_pulse", r), int'(up_pulse), int'(tbl[r].e_up));
      chk($sformatf("tbl%0d_heartbeat", r), int'(heartbeat), int'(tbl[r].e_hb));
      chk($sformatf("tbl%0d_port_idle", r), int'(port_idle), int'(tbl[r].e_idle));
      chk($sformatf("tbl%0d_timeout", r), int'(timeout), int'(tbl[r].e_state == 2'd2));
      chk($sformatf("tbl%0d_frame_count", r), int'(frame_count), int'(tbl[r].e_fc));
    end

    // ---------------- randomized traffic vs. model ----------------
    rst = 1'b0; sup = 1'b1; clr = 1'b0; dv = '0;
    for (int seg = 0; seg < 8; seg++) begin
      int rate;
      case (seg % 3)
        0: rate = 0;
        1: rate = 8;
        default: rate = 60;
      endcase
      for (int c = 0; c < 400; c++) begin
        rst = ($urandom_range(0, 999) == 0);
        if (sup) sup = ($urandom_range(0, 199) != 0);
        else     sup = ($urandom_range(0, 9) == 0);
        if (rate != 0) begin
          for (int i = 0; i < NP; i++) if ($urandom_range(0, rate) == 0) dv[i] = ~dv[i];
        end
        clr = ($urandom_range(0, 99) == 0);
        sel = 4'($urandom_range(0, 15));
        tick();
        check_model();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
